// File: rtl/led_sweep_ctrl_if.sv
// Configuration handshake bundle for led_sweep_ctrl: a valid/ready offer of a
// new {increment, mode} word into the controller's single pending slot.
interface led_sweep_ctrl_if;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [31:0] i_cfg_increment;
    logic [1:0]  i_cfg_mode;

    modport master (
        output i_cfg_valid,
        output i_cfg_increment,
        output i_cfg_mode,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_increment,
        input  i_cfg_mode,
        output o_cfg_ready
    );
endinterface

// File: rtl/led_sweep_ctrl.sv
// LED sweep controller: a 32-bit phase accumulator paces bounce/wrap/hold/blink patterns.
// Optional fading trail on the previously lit LED when LED_SWEEP_CTRL_TRAIL_EN is defined.
module led_sweep_ctrl #(
    parameter int unsigned CLOCK_RATE_HZ     = 12_000_000,
    parameter int unsigned NLEDS             = 8,
    parameter logic [31:0] DEFAULT_INCREMENT = 32'd2863
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    led_sweep_ctrl_if.slave  cfg,
    output logic             o_tick,
    output logic [NLEDS-1:0] o_led
);
    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, HOLD} state_t;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_WRAP   = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;
    localparam logic [3:0] POS_LAST    = 4'(NLEDS - 1);

    if (NLEDS < 2 || NLEDS > 16 || CLOCK_RATE_HZ == 0) begin : g_bad_params
        $error("led_sweep_ctrl: NLEDS must be 2..16 and CLOCK_RATE_HZ non-zero");
    end

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic             tick_q, tick_d;
    logic [3:0]       pos_q, pos_d;
    logic             blink_q, blink_d;
    logic [31:0]      inc_q, inc_d;
    logic [1:0]       mode_q, mode_d;
    logic             pend_vld_q, pend_vld_d;
    logic [31:0]      pend_inc_q, pend_inc_d;
    logic [1:0]       pend_mode_q, pend_mode_d;
    logic [NLEDS-1:0] led_q, led_d;

    logic [32:0]      acc_sum;
    logic             apply_cfg;
    logic             take_cfg;
    logic [1:0]       entry_mode;
    logic [NLEDS-1:0] pos_onehot;
    logic [NLEDS-1:0] trail_led;

    for (genvar gi = 0; gi < NLEDS; gi++) begin : g_pos_onehot
        assign pos_onehot[gi] = (pos_q == 4'(gi));
    end

    assign acc_sum    = {1'b0, acc_q} + {1'b0, inc_q};
    // The slot drains on a tick or in IDLE; a word accepted this cycle waits for the next one.
    assign apply_cfg  = pend_vld_q && ((state_q == IDLE) || tick_q);
    assign take_cfg   = cfg.i_cfg_valid && !pend_vld_q;
    assign entry_mode = apply_cfg ? pend_mode_q : mode_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tick_d      = 1'b0;
        pos_d       = pos_q;
        blink_d     = blink_q;
        inc_d       = inc_q;
        mode_d      = mode_q;
        pend_vld_d  = pend_vld_q;
        pend_inc_d  = pend_inc_q;
        pend_mode_d = pend_mode_q;

        if (apply_cfg) begin
            inc_d      = pend_inc_q;
            mode_d     = pend_mode_q;
            pend_vld_d = 1'b0;
        end
        if (take_cfg) begin
            pend_vld_d  = 1'b1;
            pend_inc_d  = cfg.i_cfg_increment;
            pend_mode_d = cfg.i_cfg_mode;
        end

        case (state_q)
            IDLE: begin
                acc_d   = '0;
                pos_d   = '0;
                blink_d = 1'b0;
                if (i_enable) begin
                    state_d = (entry_mode == MODE_HOLD) ? HOLD : RUN_UP;
                end
            end
            default: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    pos_d   = '0;
                    blink_d = 1'b0;
                end else begin
                    acc_d  = acc_sum[31:0];
                    tick_d = acc_sum[32];
                    if (tick_q) begin
                        if (apply_cfg) begin
                            pos_d   = '0;
                            blink_d = 1'b0;
                            state_d = (pend_mode_q == MODE_HOLD) ? HOLD : RUN_UP;
                        end else begin
                            case (mode_q)
                                MODE_BOUNCE: begin
                                    // Turn-around steps straight to the neighbour so endpoints last one tick.
                                    if (state_q == RUN_DOWN) begin
                                        if (pos_q == 4'd0) begin
                                            state_d = RUN_UP;
                                            pos_d   = 4'd1;
                                        end else begin
                                            pos_d = pos_q - 4'd1;
                                        end
                                    end else begin
                                        if (pos_q == POS_LAST) begin
                                            state_d = RUN_DOWN;
                                            pos_d   = POS_LAST - 4'd1;
                                        end else begin
                                            pos_d = pos_q + 4'd1;
                                        end
                                    end
                                end
                                MODE_WRAP:  pos_d   = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
                                MODE_BLINK: blink_d = !blink_q;
                                default:    pos_d   = pos_q;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        led_d = '0;
        if (state_q != IDLE) begin
            if (mode_q == MODE_BLINK) begin
                led_d = {NLEDS{blink_q}};
            end else begin
                led_d = pos_onehot | trail_led;
            end
        end
    end

`ifdef LED_SWEEP_CTRL_TRAIL_EN
    logic [1:0]       trail_cnt_q, trail_cnt_d;
    logic [3:0]       trail_pos_q, trail_pos_d;
    logic             trail_vld_q, trail_vld_d;
    logic [NLEDS-1:0] trail_onehot;

    for (genvar gi = 0; gi < NLEDS; gi++) begin : g_trail_onehot
        assign trail_onehot[gi] = (trail_pos_q == 4'(gi));
    end

    assign trail_led = (trail_vld_q && (trail_cnt_q == 2'd0) &&
                        ((mode_q == MODE_BOUNCE) || (mode_q == MODE_WRAP))) ? trail_onehot : '0;

    always_comb begin
        trail_cnt_d = trail_cnt_q + 2'd1;
        trail_pos_d = trail_pos_q;
        trail_vld_d = trail_vld_q;
        if ((state_q == IDLE) || !i_enable || apply_cfg) begin
            trail_vld_d = 1'b0;
        end else if (tick_q && ((mode_q == MODE_BOUNCE) || (mode_q == MODE_WRAP))) begin
            trail_pos_d = pos_q;
            trail_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            trail_cnt_q <= '0;
            trail_pos_q <= '0;
            trail_vld_q <= 1'b0;
        end else begin
            trail_cnt_q <= trail_cnt_d;
            trail_pos_q <= trail_pos_d;
            trail_vld_q <= trail_vld_d;
        end
    end
`else
    assign trail_led = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tick_q      <= 1'b0;
            pos_q       <= '0;
            blink_q     <= 1'b0;
            inc_q       <= DEFAULT_INCREMENT;
            mode_q      <= MODE_BOUNCE;
            pend_vld_q  <= 1'b0;
            pend_inc_q  <= '0;
            pend_mode_q <= MODE_BOUNCE;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tick_q      <= tick_d;
            pos_q       <= pos_d;
            blink_q     <= blink_d;
            inc_q       <= inc_d;
            mode_q      <= mode_d;
            pend_vld_q  <= pend_vld_d;
            pend_inc_q  <= pend_inc_d;
            pend_mode_q <= pend_mode_d;
            led_q       <= led_d;
        end
    end

    assign o_tick          = tick_q;
    assign o_led           = led_q;
    assign cfg.o_cfg_ready = !pend_vld_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Self-checking bench for led_sweep_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the sweep rules.
module tb_led_sweep_ctrl;
    localparam int NLEDS = 8;

    logic             i_clk = 1'b0;
    logic             i_reset_n;
    logic             i_enable;
    logic             o_tick;
    logic [NLEDS-1:0] o_led;

    led_sweep_ctrl_if cfg_if ();

    led_sweep_ctrl #(
        .CLOCK_RATE_HZ     (12_000_000),
        .NLEDS             (NLEDS),
        .DEFAULT_INCREMENT (32'd2863)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (i_enable),
        .cfg       (cfg_if),
        .o_tick    (o_tick),
        .o_led     (o_led)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: running flag plus a signed direction instead of named states.
    bit               m_run;
    int               m_pos;
    int               m_dir;
    bit               m_blink;
    logic [31:0]      m_acc;
    logic [31:0]      m_inc;
    logic [1:0]       m_mode;
    bit               m_pv;
    logic [31:0]      m_pinc;
    logic [1:0]       m_pmode;
    bit               m_tick;
    logic [NLEDS-1:0] m_led;

    task automatic model_step();
        logic [32:0]      sum;
        bit               apply;
        bit               hs;
        logic [NLEDS-1:0] led_next;
        logic [NLEDS-1:0] one;
        if (!i_reset_n) begin
            m_run = 0; m_pos = 0; m_dir = 1; m_blink = 0; m_acc = 0;
            m_inc = 32'd2863; m_mode = 0; m_pv = 0; m_tick = 0; m_led = '0;
            return;
        end
        one      = {{(NLEDS-1){1'b0}}, 1'b1};
        apply    = m_pv && (!m_run || m_tick);
        hs       = cfg_if.i_cfg_valid && !m_pv;
        led_next = '0;
        if (m_run) led_next = (m_mode == 2'd3) ? {NLEDS{m_blink}} : (one << m_pos);
        sum = {1'b0, m_acc} + {1'b0, m_inc};
        if (!m_run || !i_enable) begin
            m_run = !m_run && i_enable;
            m_acc = 0; m_tick = 0; m_pos = 0; m_dir = 1; m_blink = 0;
        end else begin
            if (m_tick) begin
                if (apply) begin
                    m_pos = 0; m_dir = 1; m_blink = 0;
                end else if (m_mode == 2'd0) begin
                    if (m_pos + m_dir < 0 || m_pos + m_dir > NLEDS - 1) m_dir = -m_dir;
                    m_pos = m_pos + m_dir;
                end else if (m_mode == 2'd1) begin
                    m_pos = (m_pos + 1) % NLEDS;
                end else if (m_mode == 2'd3) begin
                    m_blink = !m_blink;
                end
            end
            m_tick = sum[32];
            m_acc  = sum[31:0];
        end
        if (apply) begin
            m_inc = m_pinc; m_mode = m_pmode; m_pv = 0;
        end
        if (hs) begin
            m_pv = 1; m_pinc = cfg_if.i_cfg_increment; m_pmode = cfg_if.i_cfg_mode;
            $display("cfg accepted inc=%08h mode=%0d @%0t", m_pinc, m_pmode, $time);
        end
        m_led = led_next;
    endtask

    task automatic step();
        @(posedge i_clk);
        model_step();
        #1;
        check_val("tick", 32'(o_tick), 32'(m_tick));
        check_val("led", 32'(o_led), 32'(m_led));
        check_val("ready", 32'(cfg_if.o_cfg_ready), 32'(!m_pv));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer_cfg(input logic [31:0] inc, input logic [1:0] mode);
        int waited = 0;
        while (cfg_if.o_cfg_ready !== 1'b1 && waited < 2000) begin
            step();
            waited++;
        end
        check_val("cfg_wait", 32'(waited < 2000), 32'd1);
        cfg_if.i_cfg_valid     = 1'b1;
        cfg_if.i_cfg_increment = inc;
        cfg_if.i_cfg_mode      = mode;
        step();
        cfg_if.i_cfg_valid = 1'b0;
    endtask

    logic [7:0] sweep_tbl [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    initial begin
        int         idx;
        int         last_tick;
        int         n_ticks;
        bit         found;
        logic [7:0] last_led;

        i_reset_n = 1'b0;
        i_enable  = 1'b0;
        cfg_if.i_cfg_valid     = 1'b0;
        cfg_if.i_cfg_increment = '0;
        cfg_if.i_cfg_mode      = '0;
        run(2);
        check_val("rst_led", 32'(o_led), 32'h0);
        check_val("rst_tick", 32'(o_tick), 32'h0);
        check_val("rst_ready", 32'(cfg_if.o_cfg_ready), 32'h1);
        i_reset_n = 1'b1;
        step();

        // Bounce sweep at increment 2^30: tick every 4 cycles, endpoints shown once.
        offer_cfg(32'h4000_0000, 2'd0);
        step();
        i_enable  = 1'b1;
        idx       = 0;
        last_tick = -1;
        last_led  = 8'h00;
        for (int c = 0; c < 80; c++) begin
            step();
            if (o_led != last_led) begin
                if (idx < 16) check_val("sweep_seq", 32'(o_led), 32'(sweep_tbl[idx]));
                idx++;
                last_led = o_led;
            end
            if (o_tick) begin
                if (last_tick >= 0) check_val("spacing4", 32'(c - last_tick), 32'd4);
                last_tick = c;
            end
        end
        check_val("sweep_len", 32'(idx >= 16), 32'd1);

        // Drop enable while LED 5 is lit, then re-enable.
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            found = (o_led == 8'h20);
        end
        check_val("wait_pos5", 32'(found), 32'd1);
        i_enable = 1'b0;
        run(2);
        check_val("disable_led", 32'(o_led), 32'h0);
        check_val("disable_tick", 32'(o_tick), 32'h0);
        run(3);
        i_enable = 1'b1;
        run(2);
        check_val("reenable_led", 32'(o_led), 32'h01);

        // Wrap mode at increment 2^31.
        i_enable = 1'b0;
        run(2);
        offer_cfg(32'h8000_0000, 2'd1);
        step();
        i_enable  = 1'b1;
        last_led  = 8'h00;
        last_tick = -1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (o_led != last_led) begin
                if (last_led == 8'h80) check_val("wrap_80_01", 32'(o_led), 32'h01);
                last_led = o_led;
            end
            if (o_tick) begin
                if (last_tick >= 0) check_val("spacing2", 32'(c - last_tick), 32'd2);
                last_tick = c;
            end
        end

        // Handshake on a tick cycle: old config keeps ticking until the next tick.
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (o_tick) found = 1;
            else step();
        end
        check_val("wait_tick", 32'(found), 32'd1);
        cfg_if.i_cfg_valid     = 1'b1;
        cfg_if.i_cfg_increment = 32'h4000_0000;
        cfg_if.i_cfg_mode      = 2'd0;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        check_val("hs_ready_low", 32'(cfg_if.o_cfg_ready), 32'h0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = o_tick;
        end
        check_val("wait_next_tick", 32'(found), 32'd1);
        check_val("pend_at_tick", 32'(cfg_if.o_cfg_ready), 32'h0);
        step();
        check_val("applied_ready", 32'(cfg_if.o_cfg_ready), 32'h1);
        step();
        check_val("applied_pos0", 32'(o_led), 32'h01);

        // Zero increment freezes the sweep.
        i_enable = 1'b0;
        run(2);
        offer_cfg(32'h0, 2'd0);
        step();
        i_enable = 1'b1;
        n_ticks  = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (o_tick) n_ticks++;
        end
        check_val("zero_inc_ticks", 32'(n_ticks), 32'd0);
        check_val("zero_inc_led", 32'(o_led), 32'h01);

        // Reset pulse discards a held pending word.
        offer_cfg(32'h8000_0000, 2'd3);
        run(3);
        check_val("pend_held", 32'(cfg_if.o_cfg_ready), 32'h0);
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        check_val("post_rst_ready", 32'(cfg_if.o_cfg_ready), 32'h1);
        check_val("post_rst_led", 32'(o_led), 32'h0);
        n_ticks = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (o_tick) n_ticks++;
        end
        check_val("discard_ticks", 32'(n_ticks), 32'd0);
        check_val("discard_led", 32'(o_led), 32'h01);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            i_reset_n = ($urandom_range(0, 499) != 0);
            i_enable  = ($urandom_range(0, 99) < 97);
            cfg_if.i_cfg_valid     = ($urandom_range(0, 9) == 0);
            cfg_if.i_cfg_increment = ($urandom_range(0, 19) == 0) ? 32'h0 :
                                     {4'($urandom_range(1, 15)), 28'($urandom)};
            cfg_if.i_cfg_mode      = 2'($urandom_range(0, 3));
            step();
        end
        cfg_if.i_cfg_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
